// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory port: word width and the
// responder state encoding.
package cpu_mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_BUSY = 2'd1,
        DMR_RESP = 2'd2
    } dmr_state_t;

endpackage

// File: rtl/dm_responder_if.sv
// Request/response channel between the CPU load/store unit (master) and the
// data-memory responder (slave).
interface dm_responder_if;
    import cpu_mem_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [15:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dm_array.sv
// Single-port 2**ADDR_W x WORD_W data array: clocked write, combinational read
// so the responder can register the read word on its commit edge.
module dm_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle handshaked data-memory responder: one access in flight, response
// pulse LAT cycles after acceptance, back-to-back acceptance in RESP.
//
// state    | meaning
// DMR_IDLE | no access in flight, ready for a request
// DMR_BUSY | access accepted, latency counter running
// DMR_RESP | access committed, rsp_valid high, ready for the next request
module dm_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_responder_if.slave  bus
);

    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("dm_responder: LAT must be in the range 1..15");
    end

    localparam bit        LAT_ONE = (LAT == 1);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    dmr_state_t        state;
    logic [3:0]        cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [WORD_W-1:0] cap_wdata;
    logic              rsp_valid_q;
    logic [WORD_W-1:0] rsp_rdata_q;

    logic              req_ready;
    logic              accept;
    logic              commit;
    logic              direct;
    logic              src_we;
    logic [ADDR_W-1:0] src_addr;
    logic [WORD_W-1:0] src_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              addr_hi_unused;

    assign req_ready = (state == DMR_IDLE) || (state == DMR_RESP);
    assign accept    = bus.req_valid && req_ready;

    // With LAT==1 the access commits on its own acceptance edge, so the live
    // request feeds the array instead of the capture registers.
    assign direct    = accept && LAT_ONE;
    assign commit    = direct || ((state == DMR_BUSY) && (cnt == 4'd1));
    assign src_we    = direct ? bus.req_we                  : cap_we;
    assign src_addr  = direct ? bus.req_addr[ADDR_W-1:0]    : cap_addr;
    assign src_wdata = direct ? bus.req_wdata               : cap_wdata;

    assign addr_hi_unused = ^bus.req_addr[15:ADDR_W];

    dm_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (commit && src_we),
        .addr  (src_addr),
        .wdata (src_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DMR_IDLE;
            cnt         <= 4'd0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= commit;
            if (commit) begin
                rsp_rdata_q <= src_we ? '0 : mem_rdata;
            end
            if (accept) begin
                cap_we    <= bus.req_we;
                cap_addr  <= bus.req_addr[ADDR_W-1:0];
                cap_wdata <= bus.req_wdata;
            end
            case (state)
                DMR_IDLE, DMR_RESP: begin
                    if (accept) begin
                        if (LAT_ONE) begin
                            state <= DMR_RESP;
                        end else begin
                            state <= DMR_BUSY;
                            cnt   <= LAT_M1;
                        end
                    end else begin
                        state <= DMR_IDLE;
                    end
                end
                DMR_BUSY: begin
                    if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DMR_RESP;
                    end
                end
                default: state <= DMR_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: four instances with LAT=1..4 share clock
// and reset; lane index + 1 is the instance latency.
module tb_dm_responder;
    import cpu_mem_pkg::*;

    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rv  [NL];
    logic        rwe [NL];
    logic [15:0] ra  [NL];
    logic [15:0] rwd [NL];
    logic        rdy [NL];
    logic        vv  [NL];
    logic [15:0] rd  [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        dm_responder_if bus();
        assign bus.req_valid = rv[g];
        assign bus.req_we    = rwe[g];
        assign bus.req_addr  = ra[g];
        assign bus.req_wdata = rwd[g];
        assign rdy[g]        = bus.req_ready;
        assign vv[g]         = bus.rsp_valid;
        assign rd[g]         = bus.rsp_rdata;
        dm_responder #(.ADDR_W(10), .LAT(g + 1)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    typedef struct {
        int          lane;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] mdl [NL][1024];
    int          cyc = 0;
    int          pulses = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge before the accepting edge; the response is due
    // LAT cycles later, observed at the negedge.
    task automatic expect_rsp(input int lane, input logic we, input logic [15:0] addr,
                              input logic [15:0] wd);
        exp_t e;
        e.lane = lane;
        e.cyc  = cyc + lane + 1;
        if (we) begin
            e.data = 16'h0000;
            mdl[lane][addr[9:0]] = wd;
        end else begin
            e.data = mdl[lane][addr[9:0]];
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input int lane, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, input bit track);
        rv[lane]  = 1'b1;
        rwe[lane] = we;
        ra[lane]  = addr;
        rwd[lane] = wd;
        for (int i = 0; i < 64; i++) begin
            if (rdy[lane]) begin
                if (track) expect_rsp(lane, we, addr, wd);
                @(negedge clk);
                rv[lane] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("issue_timeout", 32'd0, 32'd1);
        rv[lane] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NL; g++) begin
            if (vv[g] === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk($sformatf("rsp_unexpected_l%0d", g), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_lane", g, e.lane);
                    chk($sformatf("rsp_data_l%0d", g), 32'(rd[g]), 32'(e.data));
                    chk($sformatf("rsp_cycle_l%0d", g), cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        for (int g = 0; g < NL; g++) begin
            rv[g] = 1'b0; rwe[g] = 1'b0; ra[g] = 16'h0; rwd[g] = 16'h0;
            for (int a = 0; a < 1024; a++) mdl[g][a] = 16'h0;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NL; g++) begin
            chk($sformatf("rst_ready_l%0d", g), 32'(rdy[g]), 32'd1);
            chk($sformatf("rst_valid_l%0d", g), 32'(vv[g]), 32'd0);
            chk($sformatf("rst_rdata_l%0d", g), 32'(rd[g]), 32'd0);
        end
        repeat (10) @(negedge clk);
        chk("idle_no_rsp", pulses, 32'd0);

        // LAT=2: store then load
        p0 = pulses;
        issue(1, 1'b1, 16'h0005, 16'hBEEF, 1'b1);
        issue(1, 1'b0, 16'h0005, 16'h0000, 1'b1);
        drain();
        chk("lat2_pulses", pulses - p0, 32'd2);

        // LAT=1: back-to-back store/load on consecutive cycles
        p0 = pulses;
        issue(0, 1'b1, 16'h0010, 16'h1234, 1'b1);
        issue(0, 1'b0, 16'h0010, 16'h0000, 1'b1);
        drain();
        chk("lat1_pulses", pulses - p0, 32'd2);

        // Address alias: 0x0400 wraps to 0x0000
        issue(1, 1'b1, 16'h0400, 16'hA5A5, 1'b1);
        issue(1, 1'b0, 16'h0000, 16'h0000, 1'b1);
        drain();

        // LAT=3 stall with req_valid held and addresses changing
        issue(2, 1'b1, 16'h0030, 16'h1111, 1'b1);
        issue(2, 1'b1, 16'h0031, 16'h2222, 1'b1);
        issue(2, 1'b1, 16'h0032, 16'h3333, 1'b1);
        issue(2, 1'b1, 16'h0033, 16'h4444, 1'b1);
        drain();
        p0 = pulses;
        rv[2] = 1'b1; rwe[2] = 1'b0; ra[2] = 16'h0030;
        chk("stall_ready_c0", 32'(rdy[2]), 32'd1);
        expect_rsp(2, 1'b0, 16'h0030, 16'h0000);
        @(negedge clk);
        ra[2] = 16'h0031;
        chk("stall_ready_c1", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        ra[2] = 16'h0033;
        chk("stall_ready_c2", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        ra[2] = 16'h0032;
        chk("stall_ready_c3", 32'(rdy[2]), 32'd1);
        expect_rsp(2, 1'b0, 16'h0032, 16'h0000);
        @(negedge clk);
        rv[2] = 1'b0;
        drain();
        chk("stall_pulses", pulses - p0, 32'd2);

        // LAT=4: reset one cycle after accepting a store abandons it
        issue(3, 1'b1, 16'h0020, 16'h0000, 1'b1);
        drain();
        p0 = pulses;
        issue(3, 1'b1, 16'h0020, 16'h0001, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_midop_no_rsp", pulses - p0, 32'd0);
        chk("rst_midop_ready", 32'(rdy[3]), 32'd1);
        issue(3, 1'b0, 16'h0020, 16'h0000, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
